// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite compositor.
//   - Default geometry (sprite size, visible lines) and the transparent colour.
//   - slot_attr_t: one sprite slot's attributes (x, y, img, en and, when
//     SPRITE_FLIP_EN is defined, flip_x/flip_y).
//   - idx_w / rom_addr_w: index and ROM address width helpers.
//   - image_rom_data / palette_rom_data: contents of the sprite image ROM and
//     the palette ROM, generated procedurally so the block is self-contained.
// Optional feature macro: SPRITE_FLIP_EN.
package sprite_pkg;

  localparam int          SPRITE_W_DEF    = 32;
  localparam int          SPRITE_H_DEF    = 32;
  localparam int          ACTIVE_H_DEF    = 500;
  localparam logic [11:0] TRANSPARENT_DEF = 12'h333;

  // Image index field is sized for the largest supported ROM (16 images).
  localparam int IMG_FIELD_W = 4;

  typedef struct packed {
`ifdef SPRITE_FLIP_EN
    logic                   flip_x;
    logic                   flip_y;
`endif
    logic                   en;
    logic [IMG_FIELD_W-1:0] img;
    logic [9:0]             y;
    logic [10:0]            x;
  } slot_attr_t;

  // Width of an index into n items; never zero so one-slot builds still work.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rom_addr_w(input int n_img, input int w, input int h);
    return idx_w(n_img * w * h);
  endfunction

  // Image ROM: column 0 of every image is palette index 0 (transparent);
  // every other pixel is a non-zero index mixed from the address bits.
  function automatic logic [5:0] image_rom_data(input logic [31:0] addr);
    if (addr[4:0] == 5'd0) begin
      return 6'd0;
    end
    return (addr[5:0] ^ addr[11:6] ^ {addr[12:10], 3'b000}) | 6'd1;
  endfunction

  // Palette ROM: index 0 is the transparent colour; all other entries are
  // {idx, idx ^ 6'h2A}, none of which equal the transparent colour.
  function automatic logic [11:0] palette_rom_data(input logic [5:0] idx);
    if (idx == 6'd0) begin
      return TRANSPARENT_DEF;
    end
    return {idx, idx ^ 6'h2A};
  endfunction

endpackage

// File: rtl/sprite_hit_arbiter.sv
// sprite_hit_arbiter: combinational hit test for every sprite slot plus a
// fixed-priority encoder (lowest slot number wins).
// Ports:
//   en, x, y   in   per-slot active attributes
//   px, py     in   current pixel column / line
//   hit        out  some enabled slot covers the pixel
//   slot       out  winning (lowest) slot number
//   dx, dy     out  pixel offset inside the winning sprite
module sprite_hit_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_W    = SPRITE_W_DEF,
  parameter int SPRITE_H    = SPRITE_H_DEF,
  localparam int SLOT_W     = idx_w(NUM_SPRITES),
  localparam int DX_W       = idx_w(SPRITE_W),
  localparam int DY_W       = idx_w(SPRITE_H)
) (
  input  logic [NUM_SPRITES-1:0]       en,
  input  logic [NUM_SPRITES-1:0][10:0] x,
  input  logic [NUM_SPRITES-1:0][9:0]  y,
  input  logic [10:0]                  px,
  input  logic [10:0]                  py,
  output logic                         hit,
  output logic [SLOT_W-1:0]            slot,
  output logic [DX_W-1:0]              dx,
  output logic [DY_W-1:0]              dy
);

  logic [NUM_SPRITES-1:0] slot_hit;
  logic [11:0]            diff_x [NUM_SPRITES];
  logic [11:0]            diff_y [NUM_SPRITES];
  logic [11:0]            px_ext;
  logic [11:0]            py_ext;

  assign px_ext = {1'b0, px};
  assign py_ext = {1'b0, py};

  // 12-bit compares: the explicit >= guard means a sprite near the top of the
  // coordinate range never wraps around to cover small coordinates.
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
    assign diff_x[gi]   = px_ext - {1'b0, x[gi]};
    assign diff_y[gi]   = py_ext - {2'b00, y[gi]};
    assign slot_hit[gi] = en[gi]
                        && (px_ext >= {1'b0, x[gi]})  && (diff_x[gi] < 12'(SPRITE_W))
                        && (py_ext >= {2'b00, y[gi]}) && (diff_y[gi] < 12'(SPRITE_H));
  end

  // Scan from the highest slot down so the lowest hitting slot is written last.
  always_comb begin
    hit  = 1'b0;
    slot = '0;
    dx   = '0;
    dy   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit  = 1'b1;
        slot = SLOT_W'(i);
        dx   = diff_x[i][DX_W-1:0];
        dy   = diff_y[i][DY_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: composites up to NUM_SPRITES sprites over a background
// pixel stream with a fixed 4-cycle latency (pixel_valid -> color_valid).
// Slot attributes are double-buffered: writes land in a shadow copy and
// frame_start copies every shadow slot into the active copy.
// Optional feature macro: SPRITE_FLIP_EN adds per-slot flip_x/flip_y bits and
// the attr_flip_x/attr_flip_y ports.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   attr_we/slot/x/y/img/en   shadow attribute write
//   attr_flip_x/y         (SPRITE_FLIP_EN only) flip bits for the write
//   frame_start           commit shadow -> active (includes same-cycle write)
//   pixel_valid, current_x, current_y, background_color   input pixel
//   color, color_valid    composited output pixel
// Pipeline: S1 hit/arbitrate/address, S2 image ROM, S3 palette ROM, S4 select.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int               NUM_SPRITES = 8,
  parameter int               SPRITE_W    = SPRITE_W_DEF,
  parameter int               SPRITE_H    = SPRITE_H_DEF,
  parameter int               NUM_IMAGES  = 8,
  parameter int               COLOR_BITS  = 6,
  parameter int               RGB_W       = 12,
  parameter int               ACTIVE_H    = ACTIVE_H_DEF,
  parameter logic [RGB_W-1:0] TRANSPARENT = RGB_W'(TRANSPARENT_DEF),
  localparam int              SLOT_W      = idx_w(NUM_SPRITES),
  localparam int              IMG_W       = idx_w(NUM_IMAGES),
  localparam int              DX_W        = idx_w(SPRITE_W),
  localparam int              DY_W        = idx_w(SPRITE_H),
  localparam int              ADDR_W      = rom_addr_w(NUM_IMAGES, SPRITE_W, SPRITE_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              attr_we,
  input  logic [SLOT_W-1:0] attr_slot,
  input  logic [10:0]       attr_x,
  input  logic [9:0]        attr_y,
  input  logic [IMG_W-1:0]  attr_img,
  input  logic              attr_en,
`ifdef SPRITE_FLIP_EN
  input  logic              attr_flip_x,
  input  logic              attr_flip_y,
`endif
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [10:0]       current_x,
  input  logic [10:0]       current_y,
  input  logic [RGB_W-1:0]  background_color,
  output logic [RGB_W-1:0]  color,
  output logic              color_valid
);

  // ---------------------------------------------------------------- attributes
  slot_attr_t new_attr;

  always_comb begin
    new_attr     = '0;
    new_attr.x   = attr_x;
    new_attr.y   = attr_y;
    new_attr.img = IMG_FIELD_W'(attr_img);
    new_attr.en  = attr_en;
`ifdef SPRITE_FLIP_EN
    new_attr.flip_x = attr_flip_x;
    new_attr.flip_y = attr_flip_y;
`endif
  end

  logic [NUM_SPRITES-1:0]       act_en;
  logic [NUM_SPRITES-1:0][10:0] act_x;
  logic [NUM_SPRITES-1:0][9:0]  act_y;
  logic [IMG_FIELD_W-1:0]       act_img [NUM_SPRITES];
`ifdef SPRITE_FLIP_EN
  logic [NUM_SPRITES-1:0]       act_flip_x;
  logic [NUM_SPRITES-1:0]       act_flip_y;
`endif

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_attr
    slot_attr_t shadow_reg;
    slot_attr_t active_reg;
    slot_attr_t shadow_next;
    logic       wr;

    // Out-of-range slot numbers match no generated slot and are dropped.
    assign wr          = attr_we && ({1'b0, attr_slot} == (SLOT_W + 1)'(gi));
    assign shadow_next = wr ? new_attr : shadow_reg;

    // Commit uses shadow_next so a write in the frame_start cycle is included.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_reg <= '0;
        active_reg <= '0;
      end else begin
        shadow_reg <= shadow_next;
        if (frame_start) begin
          active_reg <= shadow_next;
        end
      end
    end

    assign act_en[gi]  = active_reg.en;
    assign act_x[gi]   = active_reg.x;
    assign act_y[gi]   = active_reg.y;
    assign act_img[gi] = active_reg.img;
`ifdef SPRITE_FLIP_EN
    assign act_flip_x[gi] = active_reg.flip_x;
    assign act_flip_y[gi] = active_reg.flip_y;
`endif
  end

  // ---------------------------------------------------------------- S1
  logic                   arb_hit;
  logic [SLOT_W-1:0]      arb_slot;
  logic [DX_W-1:0]        arb_dx;
  logic [DY_W-1:0]        arb_dy;
  logic [DX_W-1:0]        dx_eff;
  logic [DY_W-1:0]        dy_eff;
  logic [IMG_FIELD_W-1:0] win_img;
  logic [ADDR_W-1:0]      rom_addr;

  sprite_hit_arbiter #(
    .NUM_SPRITES (NUM_SPRITES),
    .SPRITE_W    (SPRITE_W),
    .SPRITE_H    (SPRITE_H)
  ) u_arbiter (
    .en   (act_en),
    .x    (act_x),
    .y    (act_y),
    .px   (current_x),
    .py   (current_y),
    .hit  (arb_hit),
    .slot (arb_slot),
    .dx   (arb_dx),
    .dy   (arb_dy)
  );

  assign win_img = act_img[arb_slot];

`ifdef SPRITE_FLIP_EN
  assign dx_eff = act_flip_x[arb_slot] ? (DX_W'(SPRITE_W - 1) - arb_dx) : arb_dx;
  assign dy_eff = act_flip_y[arb_slot] ? (DY_W'(SPRITE_H - 1) - arb_dy) : arb_dy;
`else
  assign dx_eff = arb_dx;
  assign dy_eff = arb_dy;
`endif

  // Power-of-two sprite dimensions make img*W*H + dy*W + dx a plain concat.
  assign rom_addr = ADDR_W'({win_img, dy_eff, dx_eff});

  logic              s1_valid;
  logic              s1_hit;
  logic              s1_blank;
  logic [ADDR_W-1:0] s1_addr;
  logic [RGB_W-1:0]  s1_bg;

  // The delayed line number is only needed for the blanking decision, so the
  // compare happens here and only its result travels down the pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_blank <= 1'b0;
      s1_addr  <= '0;
      s1_bg    <= '0;
    end else begin
      s1_valid <= pixel_valid;
      s1_hit   <= arb_hit;
      s1_blank <= (current_y >= 11'(ACTIVE_H));
      s1_addr  <= rom_addr;
      s1_bg    <= background_color;
    end
  end

  // ---------------------------------------------------------------- S2: image ROM
  logic                  s2_valid;
  logic                  s2_hit;
  logic                  s2_blank;
  logic [COLOR_BITS-1:0] s2_pix;
  logic [RGB_W-1:0]      s2_bg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_blank <= 1'b0;
      s2_pix   <= '0;
      s2_bg    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_hit   <= s1_hit;
      s2_blank <= s1_blank;
      s2_pix   <= COLOR_BITS'(image_rom_data(32'(s1_addr)));
      s2_bg    <= s1_bg;
    end
  end

  // ---------------------------------------------------------------- S3: palette ROM
  logic             s3_valid;
  logic             s3_hit;
  logic             s3_blank;
  logic [RGB_W-1:0] s3_pal;
  logic [RGB_W-1:0] s3_bg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid <= 1'b0;
      s3_hit   <= 1'b0;
      s3_blank <= 1'b0;
      s3_pal   <= '0;
      s3_bg    <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_hit   <= s2_hit;
      s3_blank <= s2_blank;
      s3_pal   <= RGB_W'(palette_rom_data(6'(s2_pix)));
      s3_bg    <= s2_bg;
    end
  end

  // ---------------------------------------------------------------- S4: select
  // A transparent winner falls through to background, never to a lower slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color       <= '0;
      color_valid <= 1'b0;
    end else begin
      color_valid <= s3_valid;
      if (s3_valid) begin
        if (s3_blank) begin
          color <= '0;
        end else if (s3_hit && (s3_pal != TRANSPARENT)) begin
          color <= s3_pal;
        end else begin
          color <= s3_bg;
        end
      end
    end
  end

endmodule
